// File: rtl/ex_pkg.sv
// Shared encodings, ALU operation enum and EX/MEM record for the execute stage.
package ex_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_NOR  = 3'd4,
      ALU_SLT  = 3'd5,
      ALU_ZERO = 3'd6
   } alu_op_e;

   typedef struct packed {
      logic [1:0] aluop;
      logic [5:0] funct;
   } alu_ctrl_t;

   typedef struct packed {
      logic        reg_write;
      logic        memto_reg;
      logic        mem_write;
      logic        mem_read;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  write_reg;
      logic        overflow;
   } exmem_t;

   // Signed overflow of r = a + b; for a - b pass the inverted b sign.
   function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   function automatic logic fwd_hit(input logic wr_en, input logic [4:0] wr_idx, input logic [4:0] idx);
      return wr_en && (wr_idx == idx) && (idx != 5'd0);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand/control bundle, WB write-back port and EX/MEM outputs of the execute stage.
interface ex_stage_if;
   logic        IDEXRegWrite;
   logic        MemtoReg_EX;
   logic        ALUSrc_EX;
   logic        MemWrite_EX;
   logic        RegDst_EX;
   logic        MemRead_EX;
   logic [1:0]  ALUOp_EX;
   logic [31:0] Readdata1_EX;
   logic [31:0] Readdata2_EX;
   logic [31:0] Signextend_EX;
   logic [4:0]  Rs_EX;
   logic [4:0]  Rt_EX;
   logic [4:0]  Rd_EX;
   logic        RegWrite_WB;
   logic [4:0]  WriteReg_WB;
   logic [31:0] WriteData_WB;
   logic        RegWrite_MEM;
   logic        MemtoReg_MEM;
   logic        MemWrite_MEM;
   logic        MemRead_MEM;
   logic [31:0] ALUResult_MEM;
   logic [31:0] WriteData_MEM;
   logic [4:0]  WriteReg_MEM;
   logic        Overflow_MEM;

   modport master (
      output IDEXRegWrite, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX,
             ALUOp_EX, Readdata1_EX, Readdata2_EX, Signextend_EX, Rs_EX, Rt_EX, Rd_EX,
             RegWrite_WB, WriteReg_WB, WriteData_WB,
      input  RegWrite_MEM, MemtoReg_MEM, MemWrite_MEM, MemRead_MEM,
             ALUResult_MEM, WriteData_MEM, WriteReg_MEM, Overflow_MEM
   );

   modport slave (
      input  IDEXRegWrite, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX,
             ALUOp_EX, Readdata1_EX, Readdata2_EX, Signextend_EX, Rs_EX, Rt_EX, Rd_EX,
             RegWrite_WB, WriteReg_WB, WriteData_WB,
      output RegWrite_MEM, MemtoReg_MEM, MemWrite_MEM, MemRead_MEM,
             ALUResult_MEM, WriteData_MEM, WriteReg_MEM, Overflow_MEM
   );
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU: ALUOp/funct decode plus 32-bit arithmetic and signed-overflow flag.
module ex_alu
   import ex_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_ctrl_t   op,
   output logic [31:0] result,
   output logic        overflow
);

   alu_op_e     alu_op_s;
   logic [31:0] sum_s;
   logic [31:0] diff_s;

   assign sum_s  = a + b;
   assign diff_s = a - b;

   // ALU control: map ALUOp and funct onto an internal operation
   always_comb begin
      alu_op_s = ALU_ZERO;
      case (op.aluop)
         ALUOP_ADD: alu_op_s = ALU_ADD;
         ALUOP_SUB: alu_op_s = ALU_SUB;
         ALUOP_OR:  alu_op_s = ALU_OR;
         ALUOP_RTYPE: begin
            case (op.funct)
               FUNCT_ADD: alu_op_s = ALU_ADD;
               FUNCT_SUB: alu_op_s = ALU_SUB;
               FUNCT_AND: alu_op_s = ALU_AND;
               FUNCT_OR:  alu_op_s = ALU_OR;
               FUNCT_NOR: alu_op_s = ALU_NOR;
               FUNCT_SLT: alu_op_s = ALU_SLT;
               default:   alu_op_s = ALU_ZERO;
            endcase
         end
         default: alu_op_s = ALU_ZERO;
      endcase
   end

   // Datapath; only add/sub can raise overflow
   always_comb begin
      result   = 32'd0;
      overflow = 1'b0;
      case (alu_op_s)
         ALU_ADD: begin
            result   = sum_s;
            overflow = add_overflow(a[31], b[31], sum_s[31]);
         end
         ALU_SUB: begin
            result   = diff_s;
            overflow = add_overflow(a[31], ~b[31], diff_s[31]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
         default: begin
            result   = 32'd0;
            overflow = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage with EX/MEM register, flush/hold control and operand forwarding.
// Forwarding from MEM/WB is built only when EX_FORWARD_EN is defined.
module ex_stage
   import ex_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       EXMEMFlush,
   input  logic       EXMEMHold,
   ex_stage_if.slave  bus
);

   exmem_t      exmem_d;
   exmem_t      exmem_q;
   logic [31:0] fwd_a_s;
   logic [31:0] fwd_b_s;
   logic [31:0] alu_b_s;
   logic [31:0] alu_result_s;
   logic        alu_ovf_s;
   alu_ctrl_t   alu_ctrl_s;

`ifdef EX_FORWARD_EN
   // Operand A: MEM (held contents during a hold) beats WB; r0 never forwarded
   always_comb begin
      fwd_a_s = bus.Readdata1_EX;
      if (fwd_hit(exmem_q.reg_write, exmem_q.write_reg, bus.Rs_EX)) begin
         fwd_a_s = exmem_q.alu_result;
      end else if (fwd_hit(bus.RegWrite_WB, bus.WriteReg_WB, bus.Rs_EX)) begin
         fwd_a_s = bus.WriteData_WB;
      end else begin
         fwd_a_s = bus.Readdata1_EX;
      end
   end

   // Operand B, same priority as A
   always_comb begin
      fwd_b_s = bus.Readdata2_EX;
      if (fwd_hit(exmem_q.reg_write, exmem_q.write_reg, bus.Rt_EX)) begin
         fwd_b_s = exmem_q.alu_result;
      end else if (fwd_hit(bus.RegWrite_WB, bus.WriteReg_WB, bus.Rt_EX)) begin
         fwd_b_s = bus.WriteData_WB;
      end else begin
         fwd_b_s = bus.Readdata2_EX;
      end
   end
`else
   logic unused_fwd_s;

   assign fwd_a_s      = bus.Readdata1_EX;
   assign fwd_b_s      = bus.Readdata2_EX;
   assign unused_fwd_s = ^{bus.RegWrite_WB, bus.WriteReg_WB, bus.WriteData_WB, bus.Rs_EX};
`endif

   assign alu_b_s          = bus.ALUSrc_EX ? bus.Signextend_EX : fwd_b_s;
   assign alu_ctrl_s.aluop = bus.ALUOp_EX;
   assign alu_ctrl_s.funct = bus.Signextend_EX[5:0];

   ex_alu u_alu (
      .a        (fwd_a_s),
      .b        (alu_b_s),
      .op       (alu_ctrl_s),
      .result   (alu_result_s),
      .overflow (alu_ovf_s)
   );

   // EX/MEM next state: flush beats hold beats a normal load
   always_comb begin
      exmem_d = exmem_q;
      if (EXMEMFlush) begin
         exmem_d = '0;
      end else if (EXMEMHold) begin
         exmem_d = exmem_q;
      end else begin
         exmem_d.reg_write  = bus.IDEXRegWrite;
         exmem_d.memto_reg  = bus.MemtoReg_EX;
         exmem_d.mem_write  = bus.MemWrite_EX;
         exmem_d.mem_read   = bus.MemRead_EX;
         exmem_d.alu_result = alu_result_s;
         exmem_d.write_data = fwd_b_s;
         exmem_d.write_reg  = bus.RegDst_EX ? bus.Rd_EX : bus.Rt_EX;
         exmem_d.overflow   = alu_ovf_s;
      end
   end

   // EX/MEM register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exmem_q <= '0;
      end else begin
         exmem_q <= exmem_d;
      end
   end

   assign bus.RegWrite_MEM  = exmem_q.reg_write;
   assign bus.MemtoReg_MEM  = exmem_q.memto_reg;
   assign bus.MemWrite_MEM  = exmem_q.mem_write;
   assign bus.MemRead_MEM   = exmem_q.mem_read;
   assign bus.ALUResult_MEM = exmem_q.alu_result;
   assign bus.WriteData_MEM = exmem_q.write_data;
   assign bus.WriteReg_MEM  = exmem_q.write_reg;
   assign bus.Overflow_MEM  = exmem_q.overflow;

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage; expectations adapt to EX_FORWARD_EN.
module tb_ex_stage;

`ifdef EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic        rw;
      logic        mtr;
      logic        mw;
      logic        mr;
      logic [31:0] res;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic        ovf;
   } exp_t;

   logic clock;
   logic reset_n;
   logic flush;
   logic hold;
   int   errors;
   int   checks;
   exp_t sb_q[$];

   ex_stage_if bus ();

   ex_stage dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .EXMEMFlush (flush),
      .EXMEMHold  (hold),
      .bus        (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t mk(input logic rw, input logic mtr, input logic mw, input logic mr,
                               input logic [31:0] res, input logic [31:0] wd,
                               input logic [4:0] wr, input logic ovf);
      exp_t e;
      e.rw = rw; e.mtr = mtr; e.mw = mw; e.mr = mr;
      e.res = res; e.wd = wd; e.wr = wr; e.ovf = ovf;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".RegWrite"},  {31'd0, bus.RegWrite_MEM},  {31'd0, e.rw});
      chk({tag, ".MemtoReg"},  {31'd0, bus.MemtoReg_MEM},  {31'd0, e.mtr});
      chk({tag, ".MemWrite"},  {31'd0, bus.MemWrite_MEM},  {31'd0, e.mw});
      chk({tag, ".MemRead"},   {31'd0, bus.MemRead_MEM},   {31'd0, e.mr});
      chk({tag, ".ALUResult"}, bus.ALUResult_MEM,          e.res);
      chk({tag, ".WriteData"}, bus.WriteData_MEM,          e.wd);
      chk({tag, ".WriteReg"},  {27'd0, bus.WriteReg_MEM},  {27'd0, e.wr});
      chk({tag, ".Overflow"},  {31'd0, bus.Overflow_MEM},  {31'd0, e.ovf});
   endtask

   task automatic tick_check(input string tag);
      exp_t e;
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk_all(tag, e);
      end
   endtask

   task automatic instr(input logic [1:0] aluop, input logic alusrc, input logic regdst,
                        input logic regwrite, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
      bus.ALUOp_EX      = aluop;
      bus.ALUSrc_EX     = alusrc;
      bus.RegDst_EX     = regdst;
      bus.IDEXRegWrite  = regwrite;
      bus.Readdata1_EX  = r1;
      bus.Readdata2_EX  = r2;
      bus.Signextend_EX = imm;
      bus.Rs_EX         = rs;
      bus.Rt_EX         = rt;
      bus.Rd_EX         = rd;
      bus.MemtoReg_EX   = 1'b0;
      bus.MemWrite_EX   = 1'b0;
      bus.MemRead_EX    = 1'b0;
      bus.RegWrite_WB   = 1'b0;
      bus.WriteReg_WB   = 5'd0;
      bus.WriteData_WB  = 32'd0;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      reset_n = 1'b0;
      flush   = 1'b0;
      hold    = 1'b0;
      instr(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

      #3;
      chk_all("reset_initial", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      instr(2'b00, 1'b1, 1'b0, 1'b1, 32'd10, 32'h22, 32'd5, 5'd1, 5'd7, 5'd0);
      @(posedge clock);
      #1;
      chk_all("reset_held_edge", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      #4;
      reset_n = 1'b1;

      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd15, 32'h22, 5'd7, 1'b0));
      tick_check("addi_first");

      // asynchronous reset mid-cycle with nonzero inputs
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("reset_async", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      #2;
      reset_n = 1'b1;
      #1;
      chk_all("reset_released", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd15, 32'h22, 5'd7, 1'b0));
      tick_check("addi_after_reset");

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h20, 5'd2, 5'd4, 5'd5);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd5, 1'b1));
      tick_check("rtype_add_ovf");

      instr(2'b00, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10, 5'd0, 5'd3, 5'd0);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 5'd3, 1'b0));
      tick_check("write_r3");

      instr(2'b00, 1'b1, 1'b0, 1'b1, 32'h99, 32'd5, 32'd1, 5'd3, 5'd6, 5'd0);
      bus.RegWrite_WB  = 1'b1;
      bus.WriteReg_WB  = 5'd3;
      bus.WriteData_WB = 32'h20;
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, FWD ? 32'h11 : 32'h9A, 32'd5, 5'd6, 1'b0));
      tick_check("fwd_priority");

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd8, 5'd0, 5'd9);
      bus.RegWrite_WB  = 1'b1;
      bus.WriteReg_WB  = 5'd0;
      bus.WriteData_WB = 32'h55;
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 5'd9, 1'b0));
      tick_check("slt_signed_r0");

      instr(2'b00, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h1111, 32'd8, 5'd10, 5'd11, 5'd0);
      bus.MemWrite_EX  = 1'b1;
      bus.RegWrite_WB  = 1'b1;
      bus.WriteReg_WB  = 5'd11;
      bus.WriteData_WB = 32'hABCD;
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h1008, FWD ? 32'hABCD : 32'h1111, 5'd11, 1'b0));
      tick_check("store_fwd_wb");

      instr(2'b01, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'd1, 32'd0, 5'd12, 5'd13, 5'd12);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd12, 1'b1));
      tick_check("sub_ovf");

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h24, 5'd12, 5'd14, 5'd15);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, FWD ? 32'h0F0F_0F0F : 32'h0F0F_0000,
                        32'h0F0F_0F0F, 5'd15, 1'b0));
      tick_check("and_fwd_mem");

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h00FF_0000, 32'h27, 5'd1, 5'd2, 5'd16);
      bus.MemtoReg_EX = 1'b1;
      bus.MemRead_EX  = 1'b1;
      sb_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'hFF00_0000, 32'h00FF_0000, 5'd16, 1'b0));
      tick_check("nor_load_ctrl");

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3F, 5'd1, 5'd2, 5'd17);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h7FFF_FFFF, 5'd17, 1'b0));
      tick_check("bad_funct");

      instr(2'b11, 1'b1, 1'b0, 1'b1, 32'hF0, 32'd3, 32'h0F, 5'd1, 5'd18, 5'd0);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFF, 32'd3, 5'd18, 1'b0));
      tick_check("ori");

      // hold two cycles with different inputs on the bus
      instr(2'b00, 1'b1, 1'b0, 1'b1, 32'd10, 32'h22, 32'd5, 5'd1, 5'd7, 5'd0);
      hold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFF, 32'd3, 5'd18, 1'b0));
         tick_check("hold");
      end
      hold = 1'b0;

      instr(2'b00, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0, 32'h100, 5'd18, 5'd19, 5'd0);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, FWD ? 32'h1FF : 32'h101, 32'd0, 5'd19, 1'b0));
      tick_check("fwd_after_hold");

      flush = 1'b1;
      hold  = 1'b1;
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      tick_check("flush_and_hold");
      flush = 1'b0;
      hold  = 1'b0;

      instr(2'b10, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h20, 5'd2, 5'd4, 5'd5);
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd5, 1'b1));
      tick_check("rtype_add_again");

      flush = 1'b1;
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0));
      tick_check("flush_only");
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register of the five-stage MIPS pipeline. It consumes the ID/EX register outputs and forwards operands from MEM and WB. It decodes ALUOp/funct, runs the ALU and registers the results, control bits and destination register toward MEM. It also supports a synchronous bubble (flush) and a hold (stall) of the EX/MEM register.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index).
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- EXMEMFlush  input  1  load a bubble into EX/MEM next edge
- EXMEMHold  input  1  keep EX/MEM contents next edge
- IDEXRegWrite, MemtoReg_EX, ALUSrc_EX, MemWrite_EX, RegDst_EX, MemRead_EX  input  1 each  ID/EX control
- ALUOp_EX  input  2  ALU operation class
- Readdata1_EX, Readdata2_EX  input  32  register file operands
- Signextend_EX  input  32  sign-extended immediate; bits [5:0] = funct
- Rs_EX, Rt_EX, Rd_EX  input  5  register indices
- RegWrite_WB  input  1  WB stage writes register file
- WriteReg_WB  input  5  WB destination
- WriteData_WB  input  32  WB write data
- RegWrite_MEM, MemtoReg_MEM, MemWrite_MEM, MemRead_MEM  output  1 each  registered control
- ALUResult_MEM  output  32  registered ALU result
- WriteData_MEM  output  32  registered store data (forwarded Rt value)
- WriteReg_MEM  output  5  registered destination register
- Overflow_MEM  output  1  registered signed overflow flag

## Operation
- Destination: WriteReg = RegDst_EX ? Rd_EX : Rt_EX.
- Forward A (Rs), then B (Rt), each independently:
  - MEM hit: RegWrite_MEM & WriteReg_MEM==index & index!=0 -> ALUResult_MEM.
  - Else WB hit: same test on WB ports -> WriteData_WB.
  - Else Readdata.
  - MEM has priority over WB. Register 0 is never forwarded.
- ALU B input = ALUSrc_EX ? Signextend_EX : forwarded B. Store data = forwarded B, always.
- ALUOp 00 -> add; 01 -> sub; 11 -> or.
- ALUOp 10 -> decode funct:
  - 100000 add; 100010 sub; 100100 and; 100101 or; 100111 nor.
  - 101010 slt: signed compare, result 0 or 1.
  - Any other funct -> result 0, overflow 0.
- Arithmetic is 32-bit wrap-around. Overflow = signed overflow on add/sub only; 0 for all other ops.
- Overflow is a flag only. It does not suppress RegWrite.

## Timing
- Reset (reset_n low, asynchronous): every output is 0. Outputs stay 0 until the first clock edge after release.
- Latency one cycle: ID/EX values present before edge n appear on the *_MEM outputs after edge n.
- Forwarding and ALU are combinational within the cycle. No internal state besides the EX/MEM register.
- EXMEMFlush=1 at edge: all outputs load 0 (control, data, WriteReg, Overflow).
- EXMEMHold=1 (Flush=0) at edge: all outputs retain value.
- Flush and Hold together: Flush wins.
- During Hold, MEM forwarding uses the held register contents.
- Simultaneous MEM and WB hit on the same index: MEM value used.

## Configuration
- EX_FORWARD_EN defined: forwarding as above.
- EX_FORWARD_EN undefined: forwarded A/B equal Readdata1_EX/Readdata2_EX. The WB ports are ignored (left unconnected internally). All other behaviour is identical.

## Structure
- Shared package ex_pkg holds:
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, ALUOP_OR=11).
  - Funct constants.
  - Internal ALU operation enum.
- One combinational sub-module ex_alu: inputs a, b, op; outputs result, overflow. Contains ALU-control decode and arithmetic.
- Forwarding muxes and the EX/MEM register live in ex_stage.

## Test plan
- Reset: reset_n low mid-cycle with nonzero inputs -> all outputs 0 immediately. After release and one edge, outputs follow inputs.
- R-type add overflow: ALUOp=10, funct=100000, A=0x7FFFFFFF, B=1, RegDst=1, Rd=5 -> next edge ALUResult_MEM=0x80000000, Overflow_MEM=1, WriteReg_MEM=5.
- Forward priority: previous instruction writes r3 with result 0x10, WB writes r3=0x20, current Rs=3, Readdata1=0x99, add with imm 1 -> ALUResult_MEM=0x11. With EX_FORWARD_EN undefined -> 0x9A.
- slt signed: A=0xFFFFFFFF, B=1, funct=101010 -> ALUResult_MEM=1. Rt=0 with a WB write to r0 -> no forwarding.
- Store path: MemWrite=1, ALUSrc=1, imm=8, Rt forwarded from WB=0xABCD -> WriteData_MEM=0xABCD, ALUResult_MEM=base+8.
- Hold then flush: Hold=1 for 2 cycles -> outputs unchanged. Flush=1 and Hold=1 together -> all outputs 0 next edge.
